// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller.
package mux_scan_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam int DEF_SEL_W = 2;
   localparam int DEF_DWELL = 4;
   localparam int CNT_W     = 8;

endpackage : mux_scan_pkg

// File: rtl/mux_4x1.sv
// Plain 4:1 mux that the scan controller sits around.
module mux_4x1 (
   input  logic [3:0] d,
   input  logic [1:0] sel,
   output logic       y
);

   assign y = d[sel];

endmodule : mux_4x1

// File: rtl/mux_scan_ctrl_chk.sv
// Simulation checker for the scan controller configuration.
module mux_scan_ctrl_chk #(
   parameter int DWELL = 4
) (
   input logic clk,
   input logic rst
);

   // the dwell must fit the 8-bit counter and be at least one cycle
   a_dwell_range : assert property (@(posedge clk) disable iff (rst)
      ((DWELL >= 32'sd1) && (DWELL <= 32'sd255)));

endmodule : mux_scan_ctrl_chk

// File: rtl/scan_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 and flags the final cycle of each dwell.
module scan_dwell_counter
   import mux_scan_pkg::*;
#(
   parameter int DWELL = DEF_DWELL
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: clear wins, then wrap on last, else increment while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en) begin
         if (cnt_q == LAST_CNT) begin
            cnt_d = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == LAST_CNT);

endmodule : scan_dwell_counter

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through every channel, samples y_in at the end of
// each dwell and publishes the collected bits as a frame with a valid pulse.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SEL_W = DEF_SEL_W,
   parameter int DWELL = DEF_DWELL
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  cont,
   input  logic                  y_in,
   output logic [SEL_W-1:0]      sel,
   output logic                  busy,
   output logic [2**SEL_W-1:0]   frame,
   output logic                  frame_valid
);

   localparam int N = 2**SEL_W;
   localparam logic [SEL_W-1:0] SEL_LAST = {SEL_W{1'b1}};

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             busy_q, busy_d;
   logic [N-1:0]     frame_q, frame_d;
   logic             fv_q, fv_d;
   logic [N-1:0]     shadow_q, shadow_d;
   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_last;

   scan_dwell_counter #(
      .DWELL (DWELL)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .last (cnt_last)
   );

   mux_scan_ctrl_chk #(
      .DWELL (DWELL)
   ) u_chk (
      .clk (clk),
      .rst (rst)
   );

   // next-state and output computation for the IDLE/SCAN controller
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      busy_d   = busy_q;
      frame_d  = frame_q;
      fv_d     = 1'b0;
      shadow_d = shadow_q;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            sel_d   = {SEL_W{1'b0}};
            if (start) begin
               state_d  = SCAN;
               busy_d   = 1'b1;
               shadow_d = {N{1'b0}};
            end else begin
               busy_d   = 1'b0;
            end
         end
         SCAN: begin
            cnt_en = 1'b1;
            if (cnt_last) begin
               shadow_d[sel_q] = y_in;
               if (sel_q != SEL_LAST) begin
                  sel_d = sel_q + SEL_W'(1);
               end else begin
                  // last channel goes straight into the frame, not via shadow
                  frame_d        = shadow_q;
                  frame_d[N-1]   = y_in;
                  fv_d           = 1'b1;
                  sel_d          = {SEL_W{1'b0}};
                  shadow_d       = {N{1'b0}};
                  if (cont) begin
                     busy_d  = 1'b1;
                  end else begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                  end
               end
            end else begin
               sel_d = sel_q;
            end
         end
         default: begin
            state_d  = IDLE;
            sel_d    = {SEL_W{1'b0}};
            busy_d   = 1'b0;
            shadow_d = {N{1'b0}};
            cnt_clr  = 1'b1;
         end
      endcase
   end

   // controller state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= {SEL_W{1'b0}};
         busy_q   <= 1'b0;
         frame_q  <= {N{1'b0}};
         fv_q     <= 1'b0;
         shadow_q <= {N{1'b0}};
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         frame_q  <= frame_d;
         fv_q     <= fv_d;
         shadow_q <= shadow_d;
      end
   end

   assign sel         = sel_q;
   assign busy        = busy_q;
   assign frame       = frame_q;
   assign frame_valid = fv_q;

endmodule : mux_scan_ctrl

// File: tb/tb_mux_scan_ctrl.sv
// Closed-loop bench: two scan controllers (DWELL=4 and DWELL=1) each driving a mux_4x1.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cont;
   logic [3:0] din;

   logic       y4, y1;
   logic [1:0] sel4, sel1;
   logic       busy4, busy1;
   logic [3:0] frame4, frame1;
   logic       fv4, fv1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mux_4x1 u_mux4 (.d(din), .sel(sel4), .y(y4));
   mux_4x1 u_mux1 (.d(din), .sel(sel1), .y(y1));

   mux_scan_ctrl #(.SEL_W(2), .DWELL(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .y_in(y4),
      .sel(sel4), .busy(busy4), .frame(frame4), .frame_valid(fv4));

   mux_scan_ctrl #(.SEL_W(2), .DWELL(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .y_in(y1),
      .sel(sel1), .busy(busy1), .frame(frame1), .frame_valid(fv1));

   // Reference model: k = edges since the accepting edge; samples at multiples of dwell.
   bit         m_active [2];
   int         m_k      [2];
   logic [3:0] m_shadow [2];
   logic [3:0] m_frame  [2];
   logic       m_fv     [2];
   logic       m_busy   [2];
   logic [1:0] m_sel    [2];

   task automatic m_reset();
      for (int u = 0; u < 2; u++) begin
         m_active[u] = 1'b0; m_k[u] = 0; m_shadow[u] = 4'b0000;
         m_frame[u] = 4'b0000; m_fv[u] = 1'b0; m_busy[u] = 1'b0; m_sel[u] = 2'b00;
      end
   endtask

   task automatic m_step(input int u, input int dw);
      int ch;
      m_fv[u] = 1'b0;
      if (!m_active[u]) begin
         if (start) begin
            m_active[u] = 1'b1; m_k[u] = 0; m_shadow[u] = 4'b0000;
         end
      end else begin
         m_k[u] = m_k[u] + 1;
         if (m_k[u] % dw == 0) begin
            ch = (m_k[u] / dw - 1) % 4;
            m_shadow[u][ch] = din[ch];
            if (ch == 3) begin
               m_frame[u]  = m_shadow[u];
               m_fv[u]     = 1'b1;
               m_shadow[u] = 4'b0000;
               m_k[u]      = 0;
               if (!cont) m_active[u] = 1'b0;
            end
         end
      end
      m_busy[u] = m_active[u];
      m_sel[u]  = m_active[u] ? 2'((m_k[u] / dw) % 4) : 2'b00;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("sel4",   {2'b00, sel4},  {2'b00, m_sel[0]});
      check("busy4",  {3'b000, busy4}, {3'b000, m_busy[0]});
      check("frame4", frame4, m_frame[0]);
      check("fv4",    {3'b000, fv4},  {3'b000, m_fv[0]});
      check("sel1",   {2'b00, sel1},  {2'b00, m_sel[1]});
      check("busy1",  {3'b000, busy1}, {3'b000, m_busy[1]});
      check("frame1", frame1, m_frame[1]);
      check("fv1",    {3'b000, fv1},  {3'b000, m_fv[1]});
   endtask

   // One clock: update the model from the inputs present at the edge, then compare.
   task automatic cyc();
      if (rst) m_reset();
      else begin
         m_step(0, 4);
         m_step(1, 1);
      end
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic wait_fv(input int u, input int budget, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!((u == 0) ? fv4 : fv1) && n < budget);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; cont = 1'b0; din = 4'b0000;
      m_reset();
      @(negedge clk);

      // reset then idle
      repeat (3) cyc();
      rst = 1'b0;
      repeat (20) cyc();
      check("idle_sel4", {2'b00, sel4}, 4'b0000);

      // single scan, inputs 0,0,1,1
      din = 4'b1100; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_fv(0, 40, n);
      check_int("single_latency", n, 16);
      check("single_frame", frame4, 4'b1100);
      check("single_busy", {3'b000, busy4}, 4'b0000);
      repeat (5) cyc();

      // continuous mode, two frames back to back then stop
      cont = 1'b1; din = 4'b0011; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_fv(0, 40, n);
      check_int("cont_latency1", n, 16);
      check("cont_frame1", frame4, 4'b0011);
      din = 4'b1100;
      wait_fv(0, 40, n);
      check_int("cont_spacing", n, 16);
      check("cont_frame2", frame4, 4'b1100);
      cont = 1'b0;
      wait_fv(0, 40, n);
      check_int("cont_last_spacing", n, 16);
      repeat (5) cyc();
      check("cont_stop_busy", {3'b000, busy4}, 4'b0000);

      // start held high through the whole scan
      din = 4'b1010; start = 1'b1;
      cyc();
      wait_fv(0, 40, n);
      check_int("held_latency", n, 16);
      check("held_frame", frame4, 4'b1010);
      start = 1'b0;
      cyc();
      check("held_no_restart", {3'b000, busy4}, 4'b0000);
      repeat (10) cyc();

      // DWELL=1 instance, inputs 1,0,1,0
      din = 4'b0101; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_fv(1, 20, n);
      check_int("dwell1_latency", n, 4);
      check("dwell1_frame", frame1, 4'b0101);
      repeat (20) cyc();

      // reset six cycles into a scan
      din = 4'b0110; start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      #2 rst = 1'b1;
      #1;
      check("arst_sel4",   {2'b00, sel4},   4'b0000);
      check("arst_busy4",  {3'b000, busy4}, 4'b0000);
      check("arst_frame4", frame4,          4'b0000);
      check("arst_frame1", frame1,          4'b0000);
      m_reset();
      @(negedge clk);
      cyc();
      rst = 1'b0;
      cyc();
      din = 4'b1001; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_fv(0, 40, n);
      check_int("post_rst_latency", n, 16);
      check("post_rst_frame", frame4, 4'b1001);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(7) == 0);
         if ($urandom_range(15) == 0) cont = ~cont;
         if ($urandom_range(9) == 0) din = 4'($urandom);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_mux_scan_ctrl
